// File: rtl/amplitude_cursor_ctrl.sv
// Front-panel Up/Down buttons -> four 9-bit amplitude cursor rows.
// Ports: Main_CLK, Reset (sync, active-high), Btn_Up/Btn_Down (raw),
//   Sel_Channel/Sel_Cursor (target select), four cursor outputs,
//   Cursor_Changed (1-cycle pulse after a cursor changes value).
module amplitude_cursor_ctrl #(
    parameter int CURSOR_MIN   = 0,
    parameter int CURSOR_MAX   = 479,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 2500000,
    parameter int INIT_HI      = 300,
    parameter int INIT_LO      = 180
) (
    input  logic       Main_CLK,
    input  logic       Reset,
    input  logic       Btn_Up,
    input  logic       Btn_Down,
    input  logic       Sel_Channel,
    input  logic       Sel_Cursor,
    output logic [8:0] CH1_Up_Amplitude_Cursor,
    output logic [8:0] CH1_Down_Amplitude_Cursor,
    output logic [8:0] CH2_Up_Amplitude_Cursor,
    output logic [8:0] CH2_Down_Amplitude_Cursor,
    output logic       Cursor_Changed
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYC);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ?
                             REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX);

    localparam logic [9:0]      MIN10   = 10'(CURSOR_MIN);
    localparam logic [9:0]      MAX10   = 10'(CURSOR_MAX);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RATE_LAST = RPT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Index 0 = Up button, index 1 = Down button.
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      deb;
    logic [DB_W-1:0] db_cnt [2];

    logic [1:0] raw;
    assign raw = {Btn_Down, Btn_Up};

    always_ff @(posedge Main_CLK) begin
        if (Reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Both pressed counts as no direction.
    logic dir_up;
    logic dir_dn;
    logic dir_any;
    assign dir_up  = deb[0] & ~deb[1];
    assign dir_dn  = deb[1] & ~deb[0];
    assign dir_any = dir_up | dir_dn;

    state_t           state;
    state_t           state_nxt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_nxt;
    logic             step;

    always_ff @(posedge Main_CLK) begin
        if (Reset) begin
            state   <= IDLE;
            rpt_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rpt_cnt <= rpt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rpt_nxt   = rpt_cnt;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (dir_any) begin
                    step      = 1'b1;
                    rpt_nxt   = '0;
                    state_nxt = DELAY;
                end
            end
            DELAY: begin
                if (!dir_any) begin
                    rpt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (rpt_cnt == DLY_LAST) begin
                    step      = 1'b1;
                    rpt_nxt   = '0;
                    state_nxt = REPEAT;
                end else begin
                    rpt_nxt = rpt_cnt + RPT_W'(1);
                end
            end
            REPEAT: begin
                if (!dir_any) begin
                    rpt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (rpt_cnt == RATE_LAST) begin
                    step    = 1'b1;
                    rpt_nxt = '0;
                end else begin
                    rpt_nxt = rpt_cnt + RPT_W'(1);
                end
            end
            default: begin
                rpt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Target cursor and its saturated next value, computed in 10 bits.
    logic [1:0] sel;
    logic [9:0] cur;
    logic [9:0] nxt;
    assign sel = {Sel_Channel, Sel_Cursor};

    always_comb begin
        cur = '0;
        unique case (sel)
            2'b00: cur = {1'b0, CH1_Up_Amplitude_Cursor};
            2'b01: cur = {1'b0, CH1_Down_Amplitude_Cursor};
            2'b10: cur = {1'b0, CH2_Up_Amplitude_Cursor};
            2'b11: cur = {1'b0, CH2_Down_Amplitude_Cursor};
            default: cur = '0;
        endcase
        if (dir_up) begin
            nxt = (cur >= MAX10) ? MAX10 : cur + 10'd1;
        end else begin
            nxt = (cur <= MIN10) ? MIN10 : cur - 10'd1;
        end
    end

    always_ff @(posedge Main_CLK) begin
        if (Reset) begin
            CH1_Up_Amplitude_Cursor   <= 9'(INIT_HI);
            CH1_Down_Amplitude_Cursor <= 9'(INIT_LO);
            CH2_Up_Amplitude_Cursor   <= 9'(INIT_HI);
            CH2_Down_Amplitude_Cursor <= 9'(INIT_LO);
            Cursor_Changed            <= 1'b0;
        end else begin
            Cursor_Changed <= step && (nxt != cur);
            if (step) begin
                unique case (sel)
                    2'b00: CH1_Up_Amplitude_Cursor   <= nxt[8:0];
                    2'b01: CH1_Down_Amplitude_Cursor <= nxt[8:0];
                    2'b10: CH2_Up_Amplitude_Cursor   <= nxt[8:0];
                    2'b11: CH2_Down_Amplitude_Cursor <= nxt[8:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_amplitude_cursor_ctrl.sv
// Directed bench for amplitude_cursor_ctrl with short debounce and
// repeat timing so holds, repeats and saturation fit in a few thousand cycles.
module tb_amplitude_cursor_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       b_up = 1'b0;
    logic       b_dn = 1'b0;
    logic       s_ch = 1'b0;
    logic       s_cur = 1'b0;
    logic [8:0] c1u;
    logic [8:0] c1d;
    logic [8:0] c2u;
    logic [8:0] c2d;
    logic       chg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pulse_cyc[$];

    amplitude_cursor_ctrl #(
        .CURSOR_MIN(0),
        .CURSOR_MAX(479),
        .DEBOUNCE_CYC(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5),
        .INIT_HI(300),
        .INIT_LO(180)
    ) dut (
        .Main_CLK(clk),
        .Reset(rst),
        .Btn_Up(b_up),
        .Btn_Down(b_dn),
        .Sel_Channel(s_ch),
        .Sel_Cursor(s_cur),
        .CH1_Up_Amplitude_Cursor(c1u),
        .CH1_Down_Amplitude_Cursor(c1d),
        .CH2_Up_Amplitude_Cursor(c2u),
        .CH2_Down_Amplitude_Cursor(c2d),
        .Cursor_Changed(chg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (chg === 1'b1) pulse_cyc.push_back(cyc);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        checks++;
        if (chg !== 1'b0) begin
            errors++;
            $display("FAIL reset_chg got %0d want 0", chg);
        end
        rst = 1'b0;
        tick(2);
        checks++;
        if (c1u !== 9'd300) begin
            errors++;
            $display("FAIL reset_c1u got %0d want 300", c1u);
        end
        checks++;
        if (c1d !== 9'd180) begin
            errors++;
            $display("FAIL reset_c1d got %0d want 180", c1d);
        end
        checks++;
        if (c2u !== 9'd300) begin
            errors++;
            $display("FAIL reset_c2u got %0d want 300", c2u);
        end
        checks++;
        if (c2d !== 9'd180) begin
            errors++;
            $display("FAIL reset_c2d got %0d want 180", c2d);
        end
    endtask

    task automatic test_single_step;
        int p0;
        int start;
        s_ch = 1'b0;
        s_cur = 1'b0;
        p0 = pulse_cyc.size();
        start = cyc;
        b_up = 1'b1;
        tick(10);
        b_up = 1'b0;
        tick(20);
        checks++;
        if (c1u !== 9'd301) begin
            errors++;
            $display("FAIL single_c1u got %0d want 301", c1u);
        end
        checks++;
        if (pulse_cyc.size() - p0 != 1) begin
            errors++;
            $display("FAIL single_pulses got %0d want 1",
                     pulse_cyc.size() - p0);
        end else begin
            checks++;
            if (pulse_cyc[p0] - start != 7) begin
                errors++;
                $display("FAIL single_latency got %0d want 7",
                         pulse_cyc[p0] - start);
            end
        end
        checks++;
        if (c1d !== 9'd180 || c2u !== 9'd300 || c2d !== 9'd180) begin
            errors++;
            $display("FAIL single_others got %0d/%0d/%0d want 180/300/180",
                     c1d, c2u, c2d);
        end
    endtask

    task automatic test_glitch;
        int p0;
        p0 = pulse_cyc.size();
        for (int r = 0; r < 2; r++) begin
            for (int w = 1; w <= 3; w++) begin
                b_up = 1'b1;
                tick(w);
                b_up = 1'b0;
                tick(6);
            end
        end
        tick(10);
        checks++;
        if (c1u !== 9'd301) begin
            errors++;
            $display("FAIL glitch_c1u got %0d want 301", c1u);
        end
        checks++;
        if (pulse_cyc.size() != p0) begin
            errors++;
            $display("FAIL glitch_pulses got %0d want 0",
                     pulse_cyc.size() - p0);
        end
    endtask

    task automatic test_repeat;
        int p0;
        int n;
        s_ch = 1'b1;
        s_cur = 1'b1;
        p0 = pulse_cyc.size();
        b_dn = 1'b1;
        tick(60);
        b_dn = 1'b0;
        tick(20);
        n = pulse_cyc.size() - p0;
        checks++;
        if (c2d !== 9'd171) begin
            errors++;
            $display("FAIL repeat_c2d got %0d want 171", c2d);
        end
        checks++;
        if (n != 9) begin
            errors++;
            $display("FAIL repeat_pulses got %0d want 9", n);
        end else begin
            checks++;
            if (pulse_cyc[p0+1] - pulse_cyc[p0] != 20) begin
                errors++;
                $display("FAIL repeat_delay got %0d want 20",
                         pulse_cyc[p0+1] - pulse_cyc[p0]);
            end
            checks++;
            if (pulse_cyc[p0+8] - pulse_cyc[p0+7] != 5) begin
                errors++;
                $display("FAIL repeat_rate got %0d want 5",
                         pulse_cyc[p0+8] - pulse_cyc[p0+7]);
            end
        end
        checks++;
        if (c2u !== 9'd300) begin
            errors++;
            $display("FAIL repeat_c2u got %0d want 300", c2u);
        end
    endtask

    task automatic test_saturation;
        int p0;
        s_ch = 1'b0;
        s_cur = 1'b1;
        p0 = pulse_cyc.size();
        b_dn = 1'b1;
        tick(1000);
        b_dn = 1'b0;
        tick(20);
        checks++;
        if (c1d !== 9'd0) begin
            errors++;
            $display("FAIL sat_lo_val got %0d want 0", c1d);
        end
        checks++;
        if (pulse_cyc.size() - p0 != 180) begin
            errors++;
            $display("FAIL sat_lo_pulses got %0d want 180",
                     pulse_cyc.size() - p0);
        end
        p0 = pulse_cyc.size();
        b_dn = 1'b1;
        tick(10);
        b_dn = 1'b0;
        tick(20);
        checks++;
        if (c1d !== 9'd0 || pulse_cyc.size() != p0) begin
            errors++;
            $display("FAIL sat_lo_tap got %0d/%0d want 0/0",
                     c1d, pulse_cyc.size() - p0);
        end
        s_cur = 1'b0;
        p0 = pulse_cyc.size();
        b_up = 1'b1;
        tick(1000);
        b_up = 1'b0;
        tick(20);
        checks++;
        if (c1u !== 9'd479) begin
            errors++;
            $display("FAIL sat_hi_val got %0d want 479", c1u);
        end
        checks++;
        if (pulse_cyc.size() - p0 != 178) begin
            errors++;
            $display("FAIL sat_hi_pulses got %0d want 178",
                     pulse_cyc.size() - p0);
        end
        p0 = pulse_cyc.size();
        b_up = 1'b1;
        tick(10);
        b_up = 1'b0;
        tick(20);
        checks++;
        if (c1u !== 9'd479 || pulse_cyc.size() != p0) begin
            errors++;
            $display("FAIL sat_hi_tap got %0d/%0d want 479/0",
                     c1u, pulse_cyc.size() - p0);
        end
    endtask

    task automatic test_both;
        int p0;
        s_ch = 1'b1;
        s_cur = 1'b0;
        p0 = pulse_cyc.size();
        b_up = 1'b1;
        b_dn = 1'b1;
        tick(30);
        b_up = 1'b0;
        b_dn = 1'b0;
        tick(20);
        checks++;
        if (c2u !== 9'd300 || pulse_cyc.size() != p0) begin
            errors++;
            $display("FAIL both_nostep got %0d/%0d want 300/0",
                     c2u, pulse_cyc.size() - p0);
        end
    endtask

    task automatic test_reset_mid_hold;
        s_ch = 1'b1;
        s_cur = 1'b0;
        b_up = 1'b1;
        tick(40);
        checks++;
        if (c2u !== 9'd304) begin
            errors++;
            $display("FAIL hold_pre_reset got %0d want 304", c2u);
        end
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++;
        if (c1u !== 9'd300 || c1d !== 9'd180 ||
            c2u !== 9'd300 || c2d !== 9'd180) begin
            errors++;
            $display("FAIL hold_reset got %0d/%0d/%0d/%0d want 300/180/300/180",
                     c1u, c1d, c2u, c2d);
        end
        tick(6);
        checks++;
        if (c2u !== 9'd300) begin
            errors++;
            $display("FAIL hold_early got %0d want 300", c2u);
        end
        tick(1);
        checks++;
        if (c2u !== 9'd301) begin
            errors++;
            $display("FAIL hold_redebounce got %0d want 301", c2u);
        end
        tick(5);
        s_ch = 1'b0;
        tick(20);
        checks++;
        if (c1u !== 9'd302 || c2u !== 9'd301) begin
            errors++;
            $display("FAIL sel_redirect got %0d/%0d want 302/301", c1u, c2u);
        end
        b_up = 1'b0;
        tick(20);
    endtask

    initial begin
        test_reset;
        test_single_step;
        test_glitch;
        test_repeat;
        test_saturation;
        test_both;
        test_reset_mid_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
